// File: rtl/e_mdu.sv
// e_mdu: Execute-stage multiply/divide unit.
// Holds the architectural HI/LO registers and runs mult/multu/div/divu as
// fixed-latency operations. mthi/mtlo are single-cycle writes.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state, state_next;
   logic [31:0]        hi, lo, hi_tmp, lo_tmp;
   logic               div0;
   logic [CNT_W-1:0]   cnt;

   // control strobes from the output decode
   logic               ld_run, commit, dec, wr_hi, wr_lo;

   // datapath intermediates
   logic               is_mul, is_signed;
   logic [63:0]        a_ext, b_ext, prod;
   logic               sign_a, sign_b;
   logic [31:0]        mag_a, mag_b, div_safe, quo, rem;
   logic [31:0]        res_hi, res_lo;
   logic               res_div0;

   assign start  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                   (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
   assign busy   = (state == S_RUN);
   assign hi_out = hi;
   assign lo_out = lo;

   // Result computation; division works on magnitudes, then restores signs
   // so the quotient truncates toward zero and the remainder follows the dividend.
   always_comb begin
      is_mul    = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
      is_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
      a_ext     = is_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
      b_ext     = is_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
      prod      = a_ext * b_ext;
      sign_a    = is_signed & rs_val[31];
      sign_b    = is_signed & rt_val[31];
      mag_a     = sign_a ? 32'(-rs_val) : rs_val;
      mag_b     = sign_b ? 32'(-rt_val) : rt_val;
      div_safe  = (mag_b == 32'd0) ? 32'd1 : mag_b;
      quo       = mag_a / div_safe;
      rem       = mag_a % div_safe;
      res_div0  = 1'b0;
      if (is_mul) begin
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end else begin
         res_hi   = sign_a ? 32'(-rem) : rem;
         res_lo   = (sign_a ^ sign_b) ? 32'(-quo) : quo;
         res_div0 = (rt_val == 32'd0);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (cnt == CNT_W'(1)) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode: datapath control strobes; ops arriving during RUN are ignored
   always_comb begin
      ld_run = 1'b0;
      commit = 1'b0;
      dec    = 1'b0;
      wr_hi  = 1'b0;
      wr_lo  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)                  ld_run = 1'b1;
            else if (mdu_op == OP_MTHI) wr_hi  = 1'b1;
            else if (mdu_op == OP_MTLO) wr_lo  = 1'b1;
         end
         S_RUN: begin
            if (cnt == CNT_W'(1)) commit = 1'b1;
            else                  dec    = 1'b1;
         end
         default: ;
      endcase
   end

   // HI/LO, staged result and cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         hi_tmp <= '0;
         lo_tmp <= '0;
         div0   <= 1'b0;
         cnt    <= '0;
      end else begin
         if (ld_run) begin
            hi_tmp <= res_hi;
            lo_tmp <= res_lo;
            div0   <= res_div0;
            cnt    <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
         end
         if (wr_hi) hi <= rs_val;
         if (wr_lo) lo <= rs_val;
         if (dec)   cnt <= cnt - CNT_W'(1);
         if (commit) begin
            cnt <= '0;
            if (!div0) begin
               hi <= hi_tmp;
               lo <= lo_tmp;
            end
         end
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  mdu_op;
   logic [31:0] rs_val, rt_val;
   logic        start, busy;
   logic [31:0] hi_out, lo_out;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .mdu_op (mdu_op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .start  (start),
      .busy   (busy),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // advance one cycle; sample point is 1 time unit after the edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // present an op for one cycle, then count busy cycles and watch HI/LO for early change
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic early);
      logic [31:0] h0, l0;
      h0 = hi_out;
      l0 = lo_out;
      mdu_op = op; rs_val = a; rt_val = b;
      tick;
      mdu_op = 3'd0;
      n = 0;
      early = 1'b0;
      while (busy && n < 50) begin
         if (hi_out !== h0 || lo_out !== l0) early = 1'b1;
         n++;
         tick;
      end
   endtask

   task automatic test_reset;
      logic [7:0] exp_start;
      exp_start = 8'b0001_1110;
      reset = 1'b1; mdu_op = 3'd0; rs_val = '0; rt_val = '0;
      tick; tick;
      for (int i = 0; i < 8; i++) begin
         mdu_op = 3'(i);
         #1;
         checks++;
         if (start !== exp_start[i]) begin
            failures++;
            $display("FAIL start op=%0d got=%b exp=%b", i, start, exp_start[i]);
         end
      end
      mdu_op = 3'd0;
      checks++;
      if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
         failures++;
         $display("FAIL reset_state busy=%b hi=%h lo=%h exp 0/0/0", busy, hi_out, lo_out);
      end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_mult;
      int n; logic early;
      run_op(3'd1, 32'hFFFFFFFF, 32'd2, n, early);
      checks++;
      if (n !== 5 || early !== 1'b0) begin
         failures++; $display("FAIL mult_timing busy_cycles=%0d early=%b exp 5/0", n, early);
      end
      checks++;
      if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFE) begin
         failures++; $display("FAIL mult_result hi=%h lo=%h exp ffffffff/fffffffe", hi_out, lo_out);
      end
      run_op(3'd2, 32'hFFFFFFFF, 32'd2, n, early);
      checks++;
      if (n !== 5 || early !== 1'b0 || hi_out !== 32'h1 || lo_out !== 32'hFFFFFFFE) begin
         failures++;
         $display("FAIL multu n=%0d early=%b hi=%h lo=%h exp 5/0/00000001/fffffffe", n, early, hi_out, lo_out);
      end
   endtask

   task automatic test_div;
      int n; logic early;
      run_op(3'd3, 32'hFFFFFFF9, 32'd2, n, early);
      checks++;
      if (n !== 10 || early !== 1'b0) begin
         failures++; $display("FAIL div_timing busy_cycles=%0d early=%b exp 10/0", n, early);
      end
      checks++;
      if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin
         failures++; $display("FAIL div_result hi=%h lo=%h exp ffffffff/fffffffd", hi_out, lo_out);
      end
      run_op(3'd4, 32'd7, 32'd2, n, early);
      checks++;
      if (n !== 10 || hi_out !== 32'd1 || lo_out !== 32'd3) begin
         failures++; $display("FAIL divu n=%0d hi=%h lo=%h exp 10/1/3", n, hi_out, lo_out);
      end
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, n, early);
      checks++;
      if (hi_out !== 32'd0 || lo_out !== 32'h80000000) begin
         failures++; $display("FAIL div_overflow hi=%h lo=%h exp 0/80000000", hi_out, lo_out);
      end
      run_op(3'd4, 32'hFFFFFFFF, 32'd16, n, early);
      checks++;
      if (hi_out !== 32'hF || lo_out !== 32'h0FFFFFFF) begin
         failures++; $display("FAIL divu_large hi=%h lo=%h exp f/0fffffff", hi_out, lo_out);
      end
   endtask

   task automatic test_mthi_mtlo;
      mdu_op = 3'd5; rs_val = 32'h12345678;
      #1;
      checks++;
      if (start !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL mthi_cycle_t start=%b busy=%b exp 0/0", start, busy);
      end
      tick;
      mdu_op = 3'd6; rs_val = 32'h9ABCDEF0;
      checks++;
      if (hi_out !== 32'h12345678 || busy !== 1'b0) begin
         failures++; $display("FAIL mthi hi=%h busy=%b exp 12345678/0", hi_out, busy);
      end
      tick;
      mdu_op = 3'd0;
      checks++;
      if (lo_out !== 32'h9ABCDEF0 || hi_out !== 32'h12345678 || busy !== 1'b0) begin
         failures++; $display("FAIL mtlo hi=%h lo=%h busy=%b exp 12345678/9abcdef0/0", hi_out, lo_out, busy);
      end
   endtask

   task automatic test_div_zero;
      int n; logic early;
      mdu_op = 3'd5; rs_val = 32'hA; tick;
      mdu_op = 3'd6; rs_val = 32'hB; tick;
      mdu_op = 3'd0;
      run_op(3'd3, 32'd5, 32'd0, n, early);
      checks++;
      if (n !== 10 || early !== 1'b0 || hi_out !== 32'hA || lo_out !== 32'hB) begin
         failures++; $display("FAIL div_by_zero n=%0d early=%b hi=%h lo=%h exp 10/0/a/b", n, early, hi_out, lo_out);
      end
   endtask

   task automatic test_reset_mid;
      int n; logic early;
      mdu_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
      tick;          // busy cycle 1
      mdu_op = 3'd0;
      tick;          // busy cycle 2
      tick;          // busy cycle 3
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
         failures++; $display("FAIL reset_mid busy=%b hi=%h lo=%h exp 0/0/0", busy, hi_out, lo_out);
      end
      run_op(3'd2, 32'd3, 32'd4, n, early);
      checks++;
      if (n !== 5 || hi_out !== 32'd0 || lo_out !== 32'd12) begin
         failures++; $display("FAIL after_reset_multu n=%0d hi=%h lo=%h exp 5/0/c", n, hi_out, lo_out);
      end
   endtask

   task automatic test_back_to_back;
      int n; logic early; int c1, c2, k;
      run_op(3'd1, 32'd2, 32'd3, n, early);
      c1 = cyc;
      checks++;
      if (lo_out !== 32'd6) begin
         failures++; $display("FAIL b2b_first lo=%h exp 6", lo_out);
      end
      run_op(3'd1, 32'd5, 32'd7, n, early);
      c2 = cyc;
      checks++;
      if (lo_out !== 32'd35 || (c2 - c1) !== 6) begin
         failures++; $display("FAIL b2b_second lo=%h interval=%0d exp 23/6", lo_out, c2 - c1);
      end
      // mtlo while busy must be dropped
      mdu_op = 3'd1; rs_val = 32'd1; rt_val = 32'd1;
      tick;
      mdu_op = 3'd6; rs_val = 32'hDEAD;
      if (busy) $display("note: protocol violation injected: mtlo presented while busy");
      tick;
      mdu_op = 3'd0;
      checks++;
      if (lo_out !== 32'd35) begin
         failures++; $display("FAIL mtlo_while_busy lo=%h exp 23", lo_out);
      end
      k = 0;
      while (busy && k < 50) begin k++; tick; end
      checks++;
      if (k !== 4 || lo_out !== 32'd1 || hi_out !== 32'd0) begin
         failures++; $display("FAIL after_ignored_mtlo rem_busy=%0d hi=%h lo=%h exp 4/0/1", k, hi_out, lo_out);
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_mthi_mtlo;
      test_div_zero;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
